// File: rtl/serial_pattern_tx.sv
// MSB-first parallel-to-serial transmitter with valid/done framing.
// Optional zero-stuffing after MAX_ONES ones, compiled in by SERIAL_PATTERN_TX_STUFF_EN.
module serial_pattern_tx #(
  parameter int WIDTH    = 8,
  parameter int MAX_ONES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             stuffed_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || MAX_ONES < 1) begin : g_bad_param
      $error("serial_pattern_tx: WIDTH must be >= 2 and MAX_ONES >= 1");
    end
  endgenerate

  // State names the bit currently on dout; each edge decides the next one.
  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
`ifdef SERIAL_PATTERN_TX_STUFF_EN
    , S_STUFF
`endif
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             dout_q;
  logic             valid_q;
  logic             done_q;
  logic             accept;
  logic             head_bit;
  logic             last_bit;

  assign accept   = load_i && ready_q;
  assign head_bit = shreg_q[WIDTH-1];
  assign last_bit = (cnt_q == '0);

`ifdef SERIAL_PATTERN_TX_STUFF_EN
  localparam int RUN_W = $clog2(MAX_ONES + 1);

  logic [RUN_W-1:0] run_q;
  logic             stuffed_q;
  logic             stuff_due;

  assign stuff_due = (run_q == RUN_W'(MAX_ONES));
  assign stuffed_o = stuffed_q;
`else
  assign stuffed_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_STUFF_EN
      run_q     <= '0;
      stuffed_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SERIAL_PATTERN_TX_STUFF_EN
      stuffed_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            // First payload bit goes straight out; cnt_q tracks bits still held.
            state_q <= S_SHIFT;
            shreg_q <= {data_i[WIDTH-2:0], 1'b0};
            cnt_q   <= CNT_W'(WIDTH - 1);
            ready_q <= 1'b0;
            dout_q  <= data_i[WIDTH-1];
            valid_q <= 1'b1;
`ifdef SERIAL_PATTERN_TX_STUFF_EN
            run_q   <= data_i[WIDTH-1] ? RUN_W'(1) : '0;
`endif
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end

        S_SHIFT: begin
`ifdef SERIAL_PATTERN_TX_STUFF_EN
          if (stuff_due) begin
            state_q   <= S_STUFF;
            dout_q    <= 1'b0;
            valid_q   <= 1'b1;
            stuffed_q <= 1'b1;
            run_q     <= '0;
          end else
`endif
          if (last_bit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
            dout_q  <= head_bit;
            valid_q <= 1'b1;
`ifdef SERIAL_PATTERN_TX_STUFF_EN
            run_q   <= head_bit ? run_q + RUN_W'(1) : '0;
`endif
          end
        end

`ifdef SERIAL_PATTERN_TX_STUFF_EN
        S_STUFF: begin
          if (last_bit) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
          end else begin
            state_q <= S_SHIFT;
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - CNT_W'(1);
            dout_q  <= head_bit;
            valid_q <= 1'b1;
            run_q   <= head_bit ? RUN_W'(1) : '0;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          dout_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign done_o       = done_q;

endmodule
